param_simple_processor: RTL and testbench

- Parametrised successor to the team's fixed 16-bit, 8-register simple processor.
- Data width and register count are generics. Adds AND/XOR (optional), a conditional move, zero/carry flags and illegal-opcode detection.
- Instruction and immediate words arrive on din from the instruction-memory path; one instruction is executed per run handshake.
- All state is held in one module: IR, R0..R(N-1), accumulator A, result register G, flags, and the control FSM.

---
 rtl/param_simple_processor.sv | 195 +++++++++++++++++++
 tb/tb_param_simple_processor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/param_simple_processor.sv
// -----------------------------------------------------------------------------
// param_simple_processor
//
// Multi-cycle register-machine processor with configurable data width and
// register count. Executes one instruction per run handshake. The
// instruction or immediate words come in on din.
//
// Supported instructions (opcode in the top 3 bits of the instruction):
//   000 mv    RX <- RY                           (T0,T1)
//   001 mvi   RX <- immediate word on din        (T0,T1)
//   010 add   RX <- RX + RY, sets flags          (T0..T3)
//   011 sub   RX <- RX - RY, sets flags          (T0..T3)
//   101 mvnz  RX <- RY if zero_flag is clear     (T0,T1)
//   100 and / 110 xor : only when LOGIC_OPS_EN is defined, else illegal
//   111               : always illegal
//
// Optional feature macro: LOGIC_OPS_EN (AND/XOR datapath and decode).
//
// Ports:
//   clk_50MHz  - system clock, rising-edge
//   reset_n    - asynchronous active-low reset
//   run        - start request, only looked at in T0
//   din        - instruction word (T0) or immediate word (T1 of mvi)
//   done       - one-cycle pulse in the completing cycle of an instruction
//   busy       - high while in T1..T3
//   illegal    - one-cycle pulse with done for an undefined opcode
//   zero_flag  - last ALU result was zero
//   carry_flag - carry-out of add / no-borrow of sub, cleared by and/xor
//   bus_out    - internal mux bus, for observation
// -----------------------------------------------------------------------------
module param_simple_processor #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8
) (
   input  logic              clk_50MHz,
   input  logic              reset_n,
   input  logic              run,
   input  logic [DATA_W-1:0] din,
   output logic              done,
   output logic              busy,
   output logic              illegal,
   output logic              zero_flag,
   output logic              carry_flag,
   output logic [DATA_W-1:0] bus_out
);

   localparam int REG_SEL_W = $clog2(NUM_REGS);
   // Only the opcode and both register fields are kept; the low bits of the
   // instruction word carry no meaning.
   localparam int IR_W      = 3 + 2 * REG_SEL_W;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MVNZ = 3'b101;
`ifdef LOGIC_OPS_EN
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b110;
`endif

   typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

   state_t                state;
   logic [IR_W-1:0]       ir;
   logic [DATA_W-1:0]     regs [NUM_REGS];
   logic [DATA_W-1:0]     a;
   logic [DATA_W-1:0]     g;

   logic [2:0]            opcode;
   logic [REG_SEL_W-1:0]  rx;
   logic [REG_SEL_W-1:0]  ry;
   logic [2:0]            din_op;
   logic [DATA_W-1:0]     rx_val;
   logic [DATA_W-1:0]     ry_val;
   logic [DATA_W:0]       alu_res;

   // Opcodes that take the four-cycle ALU path.
   function automatic logic is_alu(input logic [2:0] op);
      logic r;
      r = (op == OP_ADD) || (op == OP_SUB);
`ifdef LOGIC_OPS_EN
      r = r || (op == OP_AND) || (op == OP_XOR);
`endif
      return r;
   endfunction

   function automatic logic is_legal(input logic [2:0] op);
      return (op == OP_MV) || (op == OP_MVI) || (op == OP_MVNZ) || is_alu(op);
   endfunction

   // Returns {carry, result}. Subtraction is x + ~y + 1, so the carry bit is
   // set exactly when x >= y (no borrow).
   function automatic logic [DATA_W:0] alu(input logic [2:0]        op,
                                           input logic [DATA_W-1:0] x,
                                           input logic [DATA_W-1:0] y);
      logic [DATA_W:0] r;
      r = '0;
      case (op)
         OP_ADD:  r = {1'b0, x} + {1'b0, y};
         OP_SUB:  r = {1'b0, x} + {1'b0, ~y} + {{DATA_W{1'b0}}, 1'b1};
`ifdef LOGIC_OPS_EN
         OP_AND:  r = {1'b0, x & y};
         OP_XOR:  r = {1'b0, x ^ y};
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   assign opcode  = ir[IR_W-1 -: 3];
   assign rx      = ir[IR_W-4 -: REG_SEL_W];
   assign ry      = ir[REG_SEL_W-1:0];
   assign din_op  = din[DATA_W-1 -: 3];
   assign rx_val  = regs[rx];
   assign ry_val  = regs[ry];
   assign alu_res = alu(opcode, a, ry_val);

   // Observation bus: shows whatever value the current step moves.
   always_comb begin
      bus_out = '0;
      case (state)
         T1: begin
            if (is_alu(opcode))                            bus_out = rx_val;
            else if (opcode == OP_MVI)                     bus_out = din;
            else if (opcode == OP_MV || opcode == OP_MVNZ) bus_out = ry_val;
            else                                           bus_out = '0;
         end
         T2:      bus_out = ry_val;
         T3:      bus_out = g;
         default: bus_out = '0;
      endcase
   end

   // Control FSM and datapath state. done/illegal/busy are registered and
   // decided on the transition into the cycle they describe.
   always_ff @(posedge clk_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         state      <= T0;
         ir         <= '0;
         a          <= '0;
         g          <= '0;
         zero_flag  <= 1'b0;
         carry_flag <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         illegal    <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
         case (state)
            T0: begin
               if (run) begin
                  ir      <= din[DATA_W-1 -: IR_W];
                  state   <= T1;
                  busy    <= 1'b1;
                  // Non-ALU and illegal opcodes finish in T1.
                  done    <= !is_alu(din_op);
                  illegal <= !is_legal(din_op);
               end
            end
            T1: begin
               if (is_alu(opcode)) begin
                  a     <= rx_val;
                  state <= T2;
               end else begin
                  state <= T0;
                  busy  <= 1'b0;
                  case (opcode)
                     OP_MV:   regs[rx] <= ry_val;
                     OP_MVI:  regs[rx] <= din;
                     OP_MVNZ: if (!zero_flag) regs[rx] <= ry_val;
                     default: ;
                  endcase
               end
            end
            T2: begin
               g          <= alu_res[DATA_W-1:0];
               carry_flag <= alu_res[DATA_W];
               zero_flag  <= (alu_res[DATA_W-1:0] == '0);
               state      <= T3;
               done       <= 1'b1;
            end
            T3: begin
               regs[rx] <= g;
               state    <= T0;
               busy     <= 1'b0;
            end
            default: state <= T0;
         endcase
      end
   end

endmodule

// File: tb/tb_param_simple_processor.sv
// -----------------------------------------------------------------------------
// tb_param_simple_processor
//
// Scoreboard bench for param_simple_processor (DATA_W=16, NUM_REGS=8).
// Stimulus pushes the expected completion record (illegal, bus_out, flags,
// busy-cycle latency) for every instruction; a monitor pops one record on
// every done pulse. Register contents are made visible by follow-up mv
// instructions, whose completion cycle shows RY on bus_out.
// Honours LOGIC_OPS_EN for the expectations of opcodes 100 and 110.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_param_simple_processor;

   logic        clk_50MHz = 1'b0;
   logic        reset_n   = 1'b0;
   logic        run       = 1'b0;
   logic [15:0] din       = '0;
   logic        done, busy, illegal, zero_flag, carry_flag;
   logic [15:0] bus_out;

   param_simple_processor #(.DATA_W(16), .NUM_REGS(8)) dut (
      .clk_50MHz (clk_50MHz),
      .reset_n   (reset_n),
      .run       (run),
      .din       (din),
      .done      (done),
      .busy      (busy),
      .illegal   (illegal),
      .zero_flag (zero_flag),
      .carry_flag(carry_flag),
      .bus_out   (bus_out)
   );

   always #10 clk_50MHz = ~clk_50MHz;

   typedef struct {
      string       name;
      logic        ill;
      logic [15:0] bus;
      logic        zf;
      logic        cf;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) $display("FAIL %s actual=%0h required=%0h", name, act, req);
      else n_pass++;
   endtask

   function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry);
      return {op, rx, ry, 7'b0};
   endfunction

   // Monitor: one expectation per done pulse.
   initial begin
      int   bcnt;
      exp_t e;
      bcnt = 0;
      forever begin
         @(negedge clk_50MHz);
         if (!reset_n) begin
            bcnt = 0;
         end else begin
            bcnt = busy ? bcnt + 1 : 0;
            if (done) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_done bus_out=%0h", bus_out);
               end else begin
                  e = exp_q.pop_front();
                  check({e.name, "_illegal"}, illegal, e.ill);
                  check({e.name, "_bus"}, bus_out, e.bus);
                  check({e.name, "_zf"}, zero_flag, e.zf);
                  check({e.name, "_cf"}, carry_flag, e.cf);
                  check({e.name, "_latency"}, bcnt, e.lat);
               end
            end else if (illegal) begin
               n_checks++;
               $display("FAIL illegal_without_done actual=1 required=0");
            end
         end
      end
   end

   task automatic push(input string name, input logic ill, input logic [15:0] bus,
                       input logic zf, input logic cf, input int lat);
      exp_t e;
      e.name = name; e.ill = ill; e.bus = bus; e.zf = zf; e.cf = cf; e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic exec(input string name, input logic [15:0] instr, input logic [15:0] imm,
                       input logic ill, input logic [15:0] bus, input logic zf,
                       input logic cf, input int lat);
      bit got;
      push(name, ill, bus, zf, cf, lat);
      @(posedge clk_50MHz); #1 run = 1'b1; din = instr;
      @(posedge clk_50MHz); #1 run = 1'b0; din = imm;
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk_50MHz);
         if (done) got = 1;
      end
      if (!got) begin
         n_checks++;
         $display("FAIL %s_timeout actual=no_done required=done", name);
      end
   endtask

   initial begin
      logic [15:0] w [3];

      // Reset state while held and in the first cycle after release.
      repeat (3) @(negedge clk_50MHz);
      check("rst_done", done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_illegal", illegal, 1'b0);
      check("rst_zf", zero_flag, 1'b0);
      check("rst_cf", carry_flag, 1'b0);
      check("rst_bus", bus_out, 16'h0);
      @(posedge clk_50MHz); #1 reset_n = 1'b1;
      @(negedge clk_50MHz);
      check("post_rst_done", done, 1'b0);
      check("post_rst_busy", busy, 1'b0);

      exec("mvi_r0",   16'h2000, 16'h0005, 0, 16'h0005, 0, 0, 1);
      exec("mvi_r1",   enc(3'b001, 3'd1, 3'd0), 16'hFFFB, 0, 16'hFFFB, 0, 0, 1);
      exec("mvi_r5",   enc(3'b001, 3'd5, 3'd0), 16'h1234, 0, 16'h1234, 0, 0, 1);
      exec("add_r0r1", enc(3'b010, 3'd0, 3'd1), 16'h0, 0, 16'h0000, 1, 1, 3);
      exec("rd_r0",    enc(3'b000, 3'd7, 3'd0), 16'h0, 0, 16'h0000, 1, 1, 1);
      exec("mvnz_z",   enc(3'b101, 3'd5, 3'd0), 16'h0, 0, 16'h0000, 1, 1, 1);
      exec("rd_r5",    enc(3'b000, 3'd7, 3'd5), 16'h0, 0, 16'h1234, 1, 1, 1);
      exec("mvi_r2",   enc(3'b001, 3'd2, 3'd0), 16'h0003, 0, 16'h0003, 1, 1, 1);
      exec("mvi_r3",   enc(3'b001, 3'd3, 3'd0), 16'h0007, 0, 16'h0007, 1, 1, 1);
      exec("sub_r2r3", enc(3'b011, 3'd2, 3'd3), 16'h0, 0, 16'hFFFC, 0, 0, 3);
      exec("rd_r2",    enc(3'b000, 3'd7, 3'd2), 16'h0, 0, 16'hFFFC, 0, 0, 1);
      exec("mvnz_nz",  enc(3'b101, 3'd4, 3'd3), 16'h0, 0, 16'h0007, 0, 0, 1);
      exec("rd_r4",    enc(3'b000, 3'd7, 3'd4), 16'h0, 0, 16'h0007, 0, 0, 1);
      exec("mvi_r6",   enc(3'b001, 3'd6, 3'd0), 16'h8001, 0, 16'h8001, 0, 0, 1);
      exec("add_r6r6", enc(3'b010, 3'd6, 3'd6), 16'h0, 0, 16'h0002, 0, 1, 3);
      exec("rd_r6",    enc(3'b000, 3'd7, 3'd6), 16'h0, 0, 16'h0002, 0, 1, 1);
      exec("sub_r3r3", enc(3'b011, 3'd3, 3'd3), 16'h0, 0, 16'h0000, 1, 1, 3);
      exec("rd_r3",    enc(3'b000, 3'd7, 3'd3), 16'h0, 0, 16'h0000, 1, 1, 1);
      exec("op111",    enc(3'b111, 3'd1, 3'd2), 16'h0, 1, 16'h0000, 1, 1, 1);
      exec("rd_r1_a",  enc(3'b000, 3'd7, 3'd1), 16'h0, 0, 16'hFFFB, 1, 1, 1);
`ifdef LOGIC_OPS_EN
      exec("and_r1r6", enc(3'b100, 3'd1, 3'd6), 16'h0, 0, 16'h0002, 0, 0, 3);
      exec("xor_r6r6", enc(3'b110, 3'd6, 3'd6), 16'h0, 0, 16'h0000, 1, 0, 3);
      exec("rd_r1_b",  enc(3'b000, 3'd7, 3'd1), 16'h0, 0, 16'h0002, 1, 0, 1);
`else
      exec("op100",    enc(3'b100, 3'd1, 3'd6), 16'h0, 1, 16'h0000, 1, 1, 1);
      exec("op110",    enc(3'b110, 3'd6, 3'd6), 16'h0, 1, 16'h0000, 1, 1, 1);
      exec("rd_r1_b",  enc(3'b000, 3'd7, 3'd1), 16'h0, 0, 16'hFFFB, 1, 1, 1);
`endif

      // Reset asserted during T2 of add R1,R1: no completion expected.
      @(posedge clk_50MHz); #1 run = 1'b1; din = enc(3'b010, 3'd1, 3'd1);
      @(posedge clk_50MHz); #1 run = 1'b0; din = '0;
      @(posedge clk_50MHz); #1 reset_n = 1'b0;
      #1;
      check("abort_done", done, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_zf", zero_flag, 1'b0);
      check("abort_cf", carry_flag, 1'b0);
      check("abort_bus", bus_out, 16'h0);
      @(posedge clk_50MHz); #1 reset_n = 1'b1;
      @(negedge clk_50MHz);
      check("abort_rel_done", done, 1'b0);
      check("abort_rel_busy", busy, 1'b0);
      exec("rd_r1_rst", enc(3'b000, 3'd7, 3'd1), 16'h0, 0, 16'h0000, 0, 0, 1);
      exec("rd_r5_rst", enc(3'b000, 3'd7, 3'd5), 16'h0, 0, 16'h0000, 0, 0, 1);

      // Back-to-back mv with run held high: done in cycles 2, 4, 6.
      exec("mvi_r2_b", enc(3'b001, 3'd2, 3'd0), 16'hAAAA, 0, 16'hAAAA, 0, 0, 1);
      w[0] = enc(3'b000, 3'd3, 3'd2);
      w[1] = enc(3'b000, 3'd4, 3'd3);
      w[2] = enc(3'b000, 3'd5, 3'd4);
      push("b2b_0", 0, 16'hAAAA, 0, 0, 1);
      push("b2b_1", 0, 16'hAAAA, 0, 0, 1);
      push("b2b_2", 0, 16'hAAAA, 0, 0, 1);
      @(posedge clk_50MHz); #1 run = 1'b1; din = w[0];
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk_50MHz);
         check($sformatf("b2b_done_c%0d", k), done, (k % 2 == 0));
         @(posedge clk_50MHz);
         #1;
         if (k < 6) din = w[k / 2];
         else       run = 1'b0;
      end

      repeat (4) @(negedge clk_50MHz);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

endmodule
